// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand and result handshake bundle for pipelined_adder.
// Operands travel producer -> adder under in_valid/in_ready, results travel
// adder -> consumer under out_valid/out_ready.
// Build option ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface pipelined_adder_if #(
    parameter int ADDER_SIZE = 1024
);
    // operand side
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDER_SIZE-1:0] A;
    logic [ADDER_SIZE-1:0] B;
    logic                  cin;
    logic                  sub;

    // result side
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDER_SIZE-1:0] out;
    logic                  cout;
`ifdef ADDER_OVF_EN
    logic                  ovf;
`endif

    // producer/consumer view: supplies operands, takes results
    modport master (
        output in_valid, A, B, cin, sub, out_ready,
`ifdef ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, out, cout
    );

    // adder view
    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
`ifdef ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, out, cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: wide adder/subtractor, one pipeline stage per SEG_WIDTH-bit
// carry segment, one operation per cycle, valid/ready on both sides.
// Stage k adds segment k of A and B' (B' = sub ? ~B : B) plus the carry left
// by stage k-1 (cin for stage 0). Operands not yet consumed travel ahead
// (skew) and finished result segments travel behind (deskew), so the last
// stage holds the complete registered result.
// Build option ADDER_OVF_EN adds the registered signed-overflow output ovf.

// adder8: 8-bit ripple-carry cell, the building block of every segment.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;

    // ripple the carry bit by bit through the cell
    always_comb begin
        // NOTE: every combinational target gets a default before any
        // conditional or partial update, so no path can infer a latch.
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[8];
endmodule

module pipelined_adder #(
    parameter int ADDER_SIZE = 1024,
    parameter int SEG_WIDTH  = 256
) (
    input  logic             clk,
    input  logic             resetn,
    pipelined_adder_if.slave bus
);
    localparam int NB_SEG  = ADDER_SIZE / SEG_WIDTH;
    localparam int NB_CELL = SEG_WIDTH / 8;
    localparam int LAST    = NB_SEG - 1;

    // stage registers: valid, sub flag, carry out, operands, partial result
    logic                  v_q   [NB_SEG];
    logic                  sub_q [NB_SEG];
    logic                  c_q   [NB_SEG];
    logic [ADDER_SIZE-1:0] a_q   [NB_SEG];
    logic [ADDER_SIZE-1:0] b_q   [NB_SEG];
    logic [ADDER_SIZE-1:0] r_q   [NB_SEG];

    // per-stage next values from the segment adders
    logic [ADDER_SIZE-1:0] r_d   [NB_SEG];
    logic                  c_d   [NB_SEG];

`ifdef ADDER_OVF_EN
    logic                  ovf_d;
    logic                  ovf_q;
`endif

    // whole pipe moves together: it advances whenever the output slot is
    // empty or being drained this cycle
    logic advance;
    logic accept;

    assign advance = ~v_q[LAST] | bus.out_ready;
    assign accept  = bus.in_valid & advance;

    for (genvar k = 0; k < NB_SEG; k++) begin : g_seg
        logic [SEG_WIDTH-1:0]  seg_a;
        logic [SEG_WIDTH-1:0]  seg_b_raw;
        logic [SEG_WIDTH-1:0]  seg_b;
        logic [SEG_WIDTH-1:0]  seg_s;
        logic [ADDER_SIZE-1:0] r_src;
        logic [ADDER_SIZE-1:0] r_nxt;
        logic                  c_src;
        logic                  s_src;
        logic [NB_CELL:0]      cc;

        if (k == 0) begin : g_head
            // first stage works straight from the operand bus
            assign seg_a     = bus.A[SEG_WIDTH-1:0];
            assign seg_b_raw = bus.B[SEG_WIDTH-1:0];
            assign r_src     = '0;
            assign c_src     = bus.cin;
            assign s_src     = bus.sub;
        end else begin : g_body
            // later stages pick their segment from the skewed operands
            assign seg_a     = a_q[k-1][k*SEG_WIDTH +: SEG_WIDTH];
            assign seg_b_raw = b_q[k-1][k*SEG_WIDTH +: SEG_WIDTH];
            assign r_src     = r_q[k-1];
            assign c_src     = c_q[k-1];
            assign s_src     = sub_q[k-1];
        end

        // subtraction inverts B segment by segment using the travelling sub bit
        assign seg_b = s_src ? ~seg_b_raw : seg_b_raw;
        assign cc[0] = c_src;

        for (genvar j = 0; j < NB_CELL; j++) begin : g_cell
            adder8 u_cell (
                .a  (seg_a[j*8 +: 8]),
                .b  (seg_b[j*8 +: 8]),
                .ci (cc[j]),
                .s  (seg_s[j*8 +: 8]),
                .co (cc[j+1])
            );
        end

        // merge this segment's sum into the result lanes already computed
        always_comb begin
            r_nxt                              = r_src;
            r_nxt[k*SEG_WIDTH +: SEG_WIDTH]    = seg_s;
        end

        assign r_d[k] = r_nxt;
        assign c_d[k] = cc[NB_CELL];

`ifdef ADDER_OVF_EN
        if (k == LAST) begin : g_ovf
            // carry into the MSB is a ^ b' ^ sum at the MSB; overflow when it
            // disagrees with the carry out of the MSB
            assign ovf_d = (seg_a[SEG_WIDTH-1] ^ seg_b[SEG_WIDTH-1] ^ seg_s[SEG_WIDTH-1])
                         ^ cc[NB_CELL];
        end
`endif
    end

    // pipeline shift: all stages move on advance, all hold otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the stage arrays are cleared along with the valid bits so
            // out and cout read 0 the moment resetn falls, not just out_valid.
            for (int k = 0; k < NB_SEG; k++) begin
                v_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking updates make every stage sample its
            // predecessor's pre-edge value, which is what makes this a pipe.
            v_q[0]   <= accept;
            sub_q[0] <= bus.sub;
            a_q[0]   <= bus.A;
            b_q[0]   <= bus.B;
            r_q[0]   <= r_d[0];
            c_q[0]   <= c_d[0];
            for (int k = 1; k < NB_SEG; k++) begin
                v_q[k]   <= v_q[k-1];
                sub_q[k] <= sub_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                r_q[k]   <= r_d[k];
                c_q[k]   <= c_d[k];
            end
        end
    end

`ifdef ADDER_OVF_EN
    // overflow flag registered alongside the last stage, held on stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // outputs come straight from the last stage registers
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.out       = r_q[LAST];
    assign bus.cout      = c_q[LAST];
endmodule
